// File: rtl/b2s_tx_handshake.sv
// b2s one-wire serial transmitter with valid/ready load handshake.
// Sends each accepted word MSB-first as a pulse-width-coded frame.
`timescale 1ns/1ps
module b2s_tx_handshake #(
   parameter int WIDTH = 32,
   parameter int UNIT  = 2,
   parameter int GAP   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             b2s_dout,
   output logic             busy,
   output logic             done
);

   localparam int PMAX = (4*UNIT > GAP) ? 4*UNIT : GAP;
   localparam int PW   = $clog2(PMAX + 1);
   localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [PW-1:0] LEN_U  = PW'(UNIT);
   localparam logic [PW-1:0] LEN_2U = PW'(2*UNIT);
   localparam logic [PW-1:0] LEN_4U = PW'(4*UNIT);
   localparam logic [PW-1:0] LEN_G  = PW'(GAP);
   localparam logic [PW-1:0] ONE    = PW'(1);

   typedef enum logic [2:0] {
      IDLE,
      START_LO,
      START_HI,
      BIT_LO,
      BIT_HI,
      GAP_S
   } state_t;

   state_t           state, state_n;
   logic [PW-1:0]    cnt, cnt_n;
   logic [BW-1:0]    bits, bits_n;
   logic [WIDTH-1:0] sh, sh_n, sh_s;
   logic             accept;
   logic             dout_n, busy_n, ready_n, done_n;

   assign accept = din_valid & din_ready;
   assign sh_s   = sh << 1;

   // next state, phase/bit counters, shifter, and next registered outputs
   always_comb begin
      state_n = state;
      cnt_n   = (cnt != '0) ? cnt - ONE : cnt;
      bits_n  = bits;
      sh_n    = sh;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_n = START_LO;
               cnt_n   = LEN_4U;
               bits_n  = BW'(WIDTH - 1);
               sh_n    = din;
            end
         end
         START_LO: begin
            if (cnt == ONE) begin
               state_n = START_HI;
               cnt_n   = LEN_U;
            end
         end
         START_HI: begin
            if (cnt == ONE) begin
               state_n = BIT_LO;
               cnt_n   = sh[WIDTH-1] ? LEN_2U : LEN_U;
            end
         end
         BIT_LO: begin
            if (cnt == ONE) begin
               state_n = BIT_HI;
               cnt_n   = LEN_U;
            end
         end
         BIT_HI: begin
            if (cnt == ONE) begin
               sh_n = sh_s;
               if (bits == '0) begin
                  state_n = GAP_S;
                  cnt_n   = LEN_G;
               end else begin
                  state_n = BIT_LO;
                  bits_n  = bits - BW'(1);
                  cnt_n   = sh_s[WIDTH-1] ? LEN_2U : LEN_U;
               end
            end
         end
         GAP_S: begin
            if (cnt == ONE) begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
      dout_n  = !((state_n == START_LO) || (state_n == BIT_LO));
      busy_n  = (state_n != IDLE);
      ready_n = (state_n == IDLE);
      done_n  = (state_n == GAP_S) && (cnt_n == ONE);
   end

   // state and registered outputs; reset aborts any frame silently
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bits      <= '0;
         sh        <= '0;
         b2s_dout  <= 1'b1;
         busy      <= 1'b0;
         din_ready <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bits      <= bits_n;
         sh        <= sh_n;
         b2s_dout  <= dout_n;
         busy      <= busy_n;
         din_ready <= ready_n;
         done      <= done_n;
      end
   end

endmodule

// File: tb/tb_b2s_tx_handshake.sv
// Bench for b2s_tx_handshake: per-cycle check against a waveform model
// built from the line-coding rules, plus a loopback pulse-width decoder.
`timescale 1ns/1ps

module tb_b2s_tx_handshake;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din_a;
  logic        dv_a, rdy_a, dout_a, busy_a, done_a;
  logic [0:0]  din_b;
  logic        dv_b, rdy_b, dout_b, busy_b, done_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  b2s_tx_handshake #(.WIDTH(32), .UNIT(2), .GAP(8)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(dv_a),
    .din_ready(rdy_a), .b2s_dout(dout_a), .busy(busy_a), .done(done_a)
  );

  b2s_tx_handshake #(.WIDTH(1), .UNIT(1), .GAP(1)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(dv_b),
    .din_ready(rdy_b), .b2s_dout(dout_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void build(input logic [31:0] w, input int width,
                                input int unit, input int gap);
    exp_q.delete();
    repeat (4*unit) exp_q.push_back(1'b0);
    repeat (unit) exp_q.push_back(1'b1);
    for (int b = width - 1; b >= 0; b--) begin
      repeat (w[b] ? 2*unit : unit) exp_q.push_back(1'b0);
      repeat (unit) exp_q.push_back(1'b1);
    end
    repeat (gap) exp_q.push_back(1'b1);
  endfunction

  function automatic int bit_start(input logic [31:0] w, input int k);
    int p = 10;
    for (int j = 0; j < k; j++) p += w[31-j] ? 6 : 4;
    return p;
  endfunction

  task automatic frame_a(input logic [31:0] w, input logic [31:0] mid,
                         input bit keep, input int abort_at);
    int run;
    int nb;
    logic [31:0] rx;
    build(w, 32, 2, 8);
    chk("a_ready_idle", rdy_a, 1'b1);
    din_a = w;
    dv_a  = 1'b1;
    tick();
    dv_a = keep;
    run  = 0;
    nb   = 0;
    rx   = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == exp_q.size() / 2) din_a = mid;
      if (i == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_dout", dout_a, 1'b1);
        chk("abort_busy", busy_a, 1'b0);
        chk("abort_done", done_a, 1'b0);
        chk("abort_ready_in_rst", rdy_a, 1'b0);
        tick();
        chk("abort_ready_after", rdy_a, 1'b1);
        chk("abort_done_after", done_a, 1'b0);
        return;
      end
      chk("a_dout", dout_a, exp_q[i]);
      chk("a_busy", busy_a, 1'b1);
      chk("a_ready_busy", rdy_a, 1'b0);
      chk("a_done", done_a, (i == exp_q.size() - 1));
      if (!dout_a) run++;
      else if (run > 0) begin
        if (run != 8) begin
          rx = {rx[30:0], (run == 4)};
          nb++;
        end
        run = 0;
      end
      tick();
    end
    chk("a_idle_dout", dout_a, 1'b1);
    chk("a_idle_busy", busy_a, 1'b0);
    chk("a_idle_ready", rdy_a, 1'b1);
    chk("a_idle_done", done_a, 1'b0);
    chk("a_rx_bits", nb, 32);
    chk("a_rx_word", rx, w);
  endtask

  task automatic frame_b(input logic w);
    build({31'd0, w}, 1, 1, 1);
    chk("b_ready_idle", rdy_b, 1'b1);
    din_b = w;
    dv_b  = 1'b1;
    tick();
    dv_b = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk("b_dout", dout_b, exp_q[i]);
      chk("b_busy", busy_b, 1'b1);
      chk("b_ready_busy", rdy_b, 1'b0);
      chk("b_done", done_b, (i == exp_q.size() - 1));
      tick();
    end
    chk("b_idle_dout", dout_b, 1'b1);
    chk("b_idle_busy", busy_b, 1'b0);
    chk("b_idle_done", done_b, 1'b0);
  endtask

  initial begin
    #2000000;
    n_fail++;
    $error("FAIL timeout: wait expired before test sequence finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    logic [31:0] w1, w2;
    rst   = 1'b1;
    dv_a  = 1'b1;
    din_a = $urandom;
    dv_b  = 1'b0;
    din_b = 1'b0;
    repeat (3) begin
      tick();
      chk("rst_dout", dout_a, 1'b1);
      chk("rst_ready", rdy_a, 1'b0);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_done", done_a, 1'b0);
    end
    rst  = 1'b0;
    dv_a = 1'b0;
    tick();
    chk("post_rst_ready", rdy_a, 1'b1);
    chk("post_rst_busy", busy_a, 1'b0);

    frame_a(32'h0000_0000, 32'h0000_0000, 1'b0, -1);
    frame_a(32'h553C_DCCF, 32'h553C_DCCF, 1'b0, -1);
    frame_a(32'hFFFF_FFFF, 32'h1234_5678, 1'b0, -1);

    w1 = $urandom;
    w2 = $urandom;
    frame_a(w1, w2, 1'b1, -1);
    frame_a(w2, w2, 1'b0, -1);

    w1 = $urandom;
    frame_a(w1, w1, 1'b0, bit_start(w1, 10) + 1);
    frame_a(32'hA5C3_0F96, 32'hA5C3_0F96, 1'b0, -1);

    repeat (4) begin
      w1 = $urandom;
      w2 = $urandom;
      frame_a(w1, w2, 1'b0, -1);
    end

    frame_b(1'b1);
    frame_b(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
